oven_cook_controller: RTL

Sequencing controller for the oven: accepts cook-time entry and start/stop buttons, counts the cook time down once per second, drives the heater with hysteresis against the target temperature, and signals completion. It owns the `current_time` value and display mode consumed by the oven seven-segment display block, and is the only block that asserts the heater.

---
 rtl/oven_pkg.sv | 19 +
 rtl/oven_tick_prescaler.sv | 32 +++
 rtl/oven_cook_controller.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/oven_pkg.sv
// rtl/oven_pkg.sv - shared oven types and constants
// Contents: state encoding, time width shared with the display block,
// default cook-time limit and the button increment amounts.
package oven_pkg;

    localparam int TIME_W           = 13;
    localparam int MAX_TIME_DEFAULT = 5999;
    localparam int ADD_MIN          = 60;
    localparam int ADD_10S          = 10;

    typedef enum logic [2:0] {
        OVEN_IDLE  = 3'd0,
        OVEN_SET   = 3'd1,
        OVEN_COOK  = 3'd2,
        OVEN_PAUSE = 3'd3,
        OVEN_DONE  = 3'd4
    } oven_state_e;

endpackage

// File: rtl/oven_tick_prescaler.sv
// rtl/oven_tick_prescaler.sv - one-second tick generator with hold and clear
// Ports: clk, rst_n (async active-low), run (count enable), clear (zero the
// count, wins over run), tick (one cycle high while running on the last count).
module oven_tick_prescaler #(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_HZ - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = run && (cnt == LAST);

    // When run is low the count holds, so a paused cook resumes mid-second.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (run) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/oven_cook_controller.sv
// rtl/oven_cook_controller.sv - oven cook sequencing FSM, countdown and heater
// Ports: clk, rst_n (async active-low); start/stop/add_min/add_10s buttons
// (levels, rising-edge detected); door_open; current_temp, target_temp;
// outputs current_time, show_temp, heater_on, done_beep, state (all registered).
// Build option: OVEN_DOOR_INTERLOCK_EN enables door handling; when undefined
// door_open is ignored.
module oven_cook_controller
    import oven_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int MAX_TIME   = MAX_TIME_DEFAULT,
    parameter int HYST       = 2,
    parameter int BEEP_TICKS = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_btn,
    input  logic              stop_btn,
    input  logic              add_min_btn,
    input  logic              add_10s_btn,
    input  logic              door_open,
    input  logic [7:0]        current_temp,
    input  logic [7:0]        target_temp,
    output logic [TIME_W-1:0] current_time,
    output logic              show_temp,
    output logic              heater_on,
    output logic              done_beep,
    output logic [2:0]        state
);

    localparam logic [2:0] ST_IDLE  = OVEN_IDLE;
    localparam logic [2:0] ST_SET   = OVEN_SET;
    localparam logic [2:0] ST_COOK  = OVEN_COOK;
    localparam logic [2:0] ST_PAUSE = OVEN_PAUSE;
    localparam logic [2:0] ST_DONE  = OVEN_DONE;

    localparam int BEEP_W = (BEEP_TICKS > 1) ? $clog2(BEEP_TICKS + 1) : 1;
    localparam logic [BEEP_W-1:0] BEEP_LAST = BEEP_W'(BEEP_TICKS - 1);

    logic start_prev, stop_prev, min_prev, s10_prev;
    logic start_ev, stop_ev, min_ev, s10_ev, add_ev;
    logic door_blk;
    logic tick, pre_run, pre_clear;
    logic [2:0] next_state;
    logic apply_add, dec, clr_time;
    logic [BEEP_W-1:0] beep_cnt, beep_next;
    logic [TIME_W:0] add_amt, time_sum;
    logic [TIME_W-1:0] time_next;
    logic time_nz, heater_next;

`ifdef OVEN_DOOR_INTERLOCK_EN
    assign door_blk = door_open;
`else
    logic door_unused;
    assign door_unused = door_open;
    assign door_blk    = 1'b0;
`endif

    assign start_ev = start_btn   & ~start_prev;
    assign stop_ev  = stop_btn    & ~stop_prev;
    assign min_ev   = add_min_btn & ~min_prev;
    assign s10_ev   = add_10s_btn & ~s10_prev;
    assign add_ev   = min_ev | s10_ev;
    assign time_nz  = (current_time != '0);

    // Both add buttons together give +70.
    assign add_amt = (min_ev ? (TIME_W+1)'(ADD_MIN) : '0)
                   + (s10_ev ? (TIME_W+1)'(ADD_10S) : '0);

    assign pre_run = (state == ST_COOK) || (state == ST_DONE);

    oven_tick_prescaler #(.CLK_HZ(CLK_HZ)) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .run   (pre_run),
        .clear (pre_clear),
        .tick  (tick)
    );

    // Priority: stop > door > start > add.
    always_comb begin
        next_state = state;
        apply_add  = 1'b0;
        dec        = 1'b0;
        clr_time   = 1'b0;
        pre_clear  = 1'b0;
        beep_next  = '0;
        case (state)
            ST_IDLE: begin
                clr_time = 1'b1;
                if (!stop_ev && add_ev) begin
                    next_state = ST_SET;
                    clr_time   = 1'b0;
                    apply_add  = 1'b1;
                end
            end
            ST_SET, ST_PAUSE: begin
                if (stop_ev) begin
                    next_state = ST_IDLE;
                    clr_time   = 1'b1;
                end else if (start_ev && !door_blk && time_nz) begin
                    next_state = ST_COOK;
                    pre_clear  = (state == ST_SET);
                end else begin
                    apply_add = add_ev;
                end
            end
            ST_COOK: begin
                // A tick coinciding with a pause is dropped.
                if (stop_ev || door_blk) begin
                    next_state = ST_PAUSE;
                end else begin
                    apply_add = add_ev;
                    dec       = tick;
                    if (tick && !add_ev && current_time == TIME_W'(1))
                        next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                clr_time = 1'b1;
                if (stop_ev || door_blk || add_ev) begin
                    next_state = ST_IDLE;
                end else begin
                    beep_next = beep_cnt;
                    if (tick) begin
                        if (beep_cnt == BEEP_LAST)
                            next_state = ST_IDLE;
                        else
                            beep_next = beep_cnt + 1'b1;
                    end
                end
            end
            default: begin
                next_state = ST_IDLE;
                clr_time   = 1'b1;
            end
        endcase
    end

    // One bit of headroom so an add past MAX_TIME saturates instead of wrapping.
    assign time_sum  = {1'b0, current_time} - {{TIME_W{1'b0}}, dec}
                     + (apply_add ? add_amt : '0);
    assign time_next = clr_time ? '0
                     : (time_sum > (TIME_W+1)'(MAX_TIME)) ? TIME_W'(MAX_TIME)
                     : time_sum[TIME_W-1:0];

    // Hysteresis only while staying in COOK; any exit drops the heater at once.
    always_comb begin
        heater_next = 1'b0;
        if (state == ST_COOK && next_state == ST_COOK) begin
            if (({1'b0, current_temp} + 9'(HYST)) < {1'b0, target_temp})
                heater_next = 1'b1;
            else if (current_temp >= target_temp)
                heater_next = 1'b0;
            else
                heater_next = heater_on;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            current_time <= '0;
            show_temp    <= 1'b0;
            heater_on    <= 1'b0;
            done_beep    <= 1'b0;
            beep_cnt     <= '0;
            start_prev   <= 1'b0;
            stop_prev    <= 1'b0;
            min_prev     <= 1'b0;
            s10_prev     <= 1'b0;
        end else begin
            state        <= next_state;
            current_time <= time_next;
            show_temp    <= (next_state == ST_COOK);
            heater_on    <= heater_next;
            done_beep    <= (next_state == ST_DONE);
            beep_cnt     <= beep_next;
            start_prev   <= start_btn;
            stop_prev    <= stop_btn;
            min_prev     <= add_min_btn;
            s10_prev     <= add_10s_btn;
        end
    end

endmodule
